prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Host-to-core program loader sequencing the UART byte receiver and 32-bit word assembler.
- Consumes assembled 32-bit words:
  - one header word, carrying magic and length;
  - N payload words, written to program memory through a valid/ack write port;
  - an optional checksum word.
- Reports busy/done/error to top level; top level holds the core in reset while busy.

Parameters:
- ADDR_WIDTH, 16, program memory word-address width; max payload 2**ADDR_WIDTH words.
- MAGIC, 16'hBA11, required value of header bits [31:16].
- BASE_ADDR, 0, word address of first payload word.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- word_in  in  32  assembled word from word assembler.
- word_valid  in  1  one-cycle pulse; word_in valid this cycle.
- clear  in  1  synchronous; returns DONE/ERROR to IDLE.
- mem_addr  out  ADDR_WIDTH  write word address.
- mem_wdata  out  32  write data.
- mem_we  out  1  write request; held until mem_ack.
- mem_ack  in  1  memory accepted write this cycle.
- busy  out  1  high in LOAD/CHECK.
- load_done  out  1  sticky success flag.
- error  out  1  sticky failure flag.
- err_code  out  2  0 none, 1 bad magic, 2 overrun, 3 checksum mismatch.
- words_loaded  out  ADDR_WIDTH+1  payload words acknowledged so far.

Behaviour:
- Reset (async, any state, mid-write included):
  - state=IDLE; every output 0; count=0; pending write dropped.
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- IDLE, on word_valid:
  - If word_in[31:16]!=MAGIC: go to ERROR, err_code=1.
  - Else: len=word_in[15:0] zero-extended to ADDR_WIDTH+1 bits; addr=BASE_ADDR; count=0.
  - len==0: go to DONE (or CHECK if CHECKSUM_EN).
  - len>2**ADDR_WIDTH: go to ERROR, err_code=1.
  - Otherwise: go to LOAD.
- LOAD, on word_valid with no write pending:
  - Next cycle: mem_we=1, mem_wdata=word_in, mem_addr=addr.
- LOAD, mem_we&&mem_ack:
  - In that cycle: mem_we drops next cycle; addr+1 mod 2**ADDR_WIDTH; count+1; words_loaded=count+1.
  - If count+1==len: go to DONE (or CHECK).
- LOAD, word_valid while mem_we && !mem_ack: go to ERROR, err_code=2; mem_we drops next cycle.
- LOAD, word_valid and mem_ack in the same cycle: legal; ack retires the old word and the new word issues next cycle.
- Latency: word_valid to mem_we is 1 cycle.
- DONE: load_done=1, busy=0; word_valid ignored; clear goes to IDLE with flags cleared.
- ERROR: error=1, busy=0; err_code held; word_valid ignored; clear goes to IDLE.
- clear in IDLE/LOAD/CHECK: no effect. Rationale: an abort mid-load requires rst.
- Flags:
  - load_done and error are mutually exclusive and never high together.
  - busy=1 only in LOAD/CHECK.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With macro:
  - Running XOR of all acknowledged payload words, reset to 0 at header acceptance.
  - After the last ack, go to CHECK and wait for the next word_valid:
    - equal to XOR: go to DONE;
    - not equal: go to ERROR, err_code=3.
  - A word arriving before the last ack is an overrun (code 2).
  - len==0 expects checksum word 0.
- Without macro: CHECK state absent; err_code 3 never produced; DONE immediately after last ack.

Decomposition:
- Package prog_loader_pkg:
  - state enum (IDLE, LOAD, CHECK, DONE, ERROR);
  - err_code enum (ERR_NONE, ERR_MAGIC, ERR_OVERRUN, ERR_CSUM);
  - default MAGIC constant;
  - header field positions (MAGIC_HI=31, MAGIC_LO=16, LEN_HI=15).
- Sub-module: loader_wr_port. Single-entry write holding register: mem_we/addr/wdata with ack retire and overrun detect. The FSM stays in prog_loader.

Test Plan:
- Header 0xBA110003, words 0x11,0x22,0x33, mem_ack 2 cycles after each mem_we -> addresses 0,1,2 written with those values, words_loaded=3, load_done=1, error=0.
- Header 0xDEAD0003 -> error=1, err_code=1, no mem_we ever asserted.
- Header 0xBA110002, mem_ack held low, two payload words back-to-back -> error=1, err_code=2, mem_we low next cycle.
- Header 0xBA110000 -> load_done next cycle, words_loaded=0; with CHECKSUM_EN, also requires word 0x0.
- CHECKSUM_EN: header 0xBA110002, words 0xF0F0F0F0,0x0F0F0F0F, checksum 0xFFFFFFFF -> load_done. Same sequence with checksum 0xFFFFFFFE -> err_code=3.
- rst pulsed while mem_we=1 in LOAD -> all outputs 0 immediately. Then clear after DONE and a new header -> second load starts at BASE_ADDR.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and header layout for the host-to-core program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MAGIC,
    ERR_OVERRUN,
    ERR_CSUM
  } err_t;

  localparam logic [15:0] MAGIC_DEFAULT = 16'hBA11;

  localparam int MAGIC_HI = 31;
  localparam int MAGIC_LO = 16;
  localparam int LEN_HI   = 15;

endpackage

// File: rtl/loader_wr_port.sv
// Single-entry write holding register: holds mem_we/addr/wdata until mem_ack,
// and flags a new word that arrives while an unacknowledged write is pending.
module loader_wr_port
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  offer,
  input  logic [ADDR_WIDTH-1:0] offer_addr,
  input  logic [31:0]           offer_data,
  input  logic                  mem_ack,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  retire,
  output logic                  overrun
);

  logic issue;

  // An ack in the same cycle frees the slot, so a new word may issue then.
  assign retire  = mem_we && mem_ack;
  assign issue   = offer && (!mem_we || mem_ack);
  assign overrun = offer && mem_we && !mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_we    <= 1'b1;
      mem_addr  <= offer_addr;
      mem_wdata <= offer_data;
    end else if (retire || overrun) begin
      mem_we    <= 1'b0;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader FSM: header check, payload writes, optional trailing checksum.
// Define PROG_LOADER_CHECKSUM_EN to require an XOR checksum word after the payload.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [15:0] MAGIC      = MAGIC_DEFAULT,
  parameter int          BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           word_in,
  input  logic                  word_valid,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  load_done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int LW = ADDR_WIDTH + 1;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = CHECK;
`else
  localparam state_t AFTER_LOAD = DONE;
`endif

  state_t                state, state_next;
  err_t                  err_q, err_next;
  logic [LW-1:0]         len_q, count_q, count_inc;
  logic [ADDR_WIDTH-1:0] addr_q, addr_inc;
  logic [31:0]           hdr_len;
  logic                  magic_ok, len_ok, hdr_accept, last_ack;
  logic                  offer, retire, overrun;

  assign hdr_len    = {16'd0, word_in[LEN_HI:0]};
  assign magic_ok   = (word_in[MAGIC_HI:MAGIC_LO] == MAGIC);
  assign len_ok     = (hdr_len <= (32'd1 << ADDR_WIDTH));
  assign hdr_accept = (state == IDLE) && word_valid && magic_ok && len_ok;
  assign count_inc  = count_q + LW'(1);
  assign addr_inc   = addr_q + ADDR_WIDTH'(1);
  assign last_ack   = retire && (count_inc == len_q);
  // A word landing on the final ack has no slot left in the payload.
  assign offer      = word_valid && (state == LOAD) && !last_ack;

  loader_wr_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_port (
    .clk        (clk),
    .rst        (rst),
    .offer      (offer),
    .offer_addr (retire ? addr_inc : addr_q),
    .offer_data (word_in),
    .mem_ack    (mem_ack),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .retire     (retire),
    .overrun    (overrun)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             csum_q <= '0;
    else if (hdr_accept) csum_q <= '0;
    else if (retire)     csum_q <= csum_q ^ mem_wdata;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      err_q <= ERR_NONE;
    end else begin
      state <= state_next;
      err_q <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = err_q;
    case (state)
      IDLE: begin
        if (word_valid) begin
          if (!magic_ok || !len_ok) begin
            state_next = ERROR;
            err_next   = ERR_MAGIC;
          end else if (hdr_len == 32'd0) begin
            state_next = AFTER_LOAD;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (overrun) begin
          state_next = ERROR;
          err_next   = ERR_OVERRUN;
        end else if (last_ack) begin
          state_next = AFTER_LOAD;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: begin
        if (word_valid) begin
          if (word_in == csum_q) begin
            state_next = DONE;
          end else begin
            state_next = ERROR;
            err_next   = ERR_CSUM;
          end
        end
      end
`endif
      DONE, ERROR: begin
        if (clear) begin
          state_next = IDLE;
          err_next   = ERR_NONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == LOAD) || (state == CHECK);
    load_done = (state == DONE);
    error     = (state == ERROR);
    err_code  = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
    end else if (hdr_accept) begin
      len_q   <= LW'(hdr_len);
      count_q <= '0;
      addr_q  <= ADDR_WIDTH'(BASE_ADDR);
    end else if (retire) begin
      count_q <= count_inc;
      addr_q  <= addr_inc;
    end else if (clear && ((state == DONE) || (state == ERROR))) begin
      count_q <= '0;
    end
  end

  assign words_loaded = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a transaction-level model.
module tb_prog_loader;

  localparam int          AW    = 16;
  localparam logic [15:0] MAGIC = 16'hBA11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   word_in = '0;
  logic          word_valid = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_ack = 1'b0;
  logic          busy, load_done, error;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;

  int tests = 0;
  int fails = 0;

  logic [AW+31:0] wr_log[$];
  logic [31:0]    pl[$];
  int             we_cycles = 0;
  bit             ack_en = 1'b1;
  int             ack_delay = 1;
  int             ack_wait = 0;

  prog_loader #(.ADDR_WIDTH(AW), .MAGIC(MAGIC), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .clear        (clear),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .busy         (busy),
    .load_done    (load_done),
    .error        (error),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Memory side: acknowledge each write ack_delay cycles after it appears.
  initial forever begin
    @(posedge clk); #1;
    if (ack_en) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        ack_wait = 0;
      end else if (mem_we === 1'b1) begin
        ack_wait++;
        if (ack_wait >= ack_delay) begin
          mem_ack = 1'b1;
          ack_wait = 0;
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cycles++;
    if (mem_we === 1'b1 && mem_ack === 1'b1) wr_log.push_back({mem_addr, mem_wdata});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    word_in = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_wr_idle();
    int n = 0;
    while (mem_we === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (mem_we === 1'b1) begin
      fails++;
      $display("FAIL wr_timeout: mem_we=%b after %0d cycles, required 0", mem_we, n);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drive_load(input logic [31:0] hdr, input logic [31:0] csum_word);
    wr_log.delete();
    we_cycles = 0;
    send_word(hdr);
    foreach (pl[i]) begin
      wait_wr_idle();
      send_word(pl[i]);
    end
    wait_wr_idle();
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(csum_word);
`else
    word_in = csum_word;
`endif
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", load_done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL reset_code got %0d want 0", err_code); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", mem_we); end
    tests++; if (words_loaded !== '0) begin fails++; $display("FAIL reset_count got %0d want 0", words_loaded); end
    tests++; if (mem_addr !== '0 || mem_wdata !== '0) begin
      fails++; $display("FAIL reset_bus got addr=%h data=%h want 0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            we_before;
    pl = '{32'h11, 32'h22, 32'h33};
    ack_delay = 2;
    drive_load(32'hBA110003, 32'h11 ^ 32'h22 ^ 32'h33);
    tests++; if (wr_log.size() != 3) begin fails++; $display("FAIL basic_nwr got %0d want 3", wr_log.size()); end
    foreach (wr_log[i]) begin
      a = wr_log[i][AW+31:32];
      d = wr_log[i][31:0];
      tests++;
      if (i < 3 && (a !== AW'(i) || d !== pl[i])) begin
        fails++; $display("FAIL basic_wr%0d got %h:%h want %h:%h", i, a, d, AW'(i), pl[i]);
      end
    end
    tests++; if (words_loaded !== 17'd3) begin fails++; $display("FAIL basic_count got %0d want 3", words_loaded); end
    tests++; if (load_done !== 1'b1 || error !== 1'b0) begin
      fails++; $display("FAIL basic_flags got done=%b err=%b want 1/0", load_done, error);
    end
    we_before = we_cycles;
    send_word(32'hBA110001);
    tick();
    tests++; if (load_done !== 1'b1 || busy !== 1'b0 || we_cycles != we_before) begin
      fails++; $display("FAIL done_ignores got done=%b busy=%b we=%0d want 1/0/%0d", load_done, busy, we_cycles, we_before);
    end
    do_clear();
    tests++; if (load_done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0) begin
      fails++; $display("FAIL clear_flags got done=%b err=%b code=%0d want 0/0/0", load_done, error, err_code);
    end
  endtask

  task automatic test_bad_magic();
    pl = '{32'h1, 32'h2, 32'h3};
    drive_load(32'hDEAD0003, 32'h0);
    tests++; if (error !== 1'b1 || err_code !== 2'd1) begin
      fails++; $display("FAIL magic_err got err=%b code=%0d want 1/1", error, err_code);
    end
    tests++; if (we_cycles != 0) begin fails++; $display("FAIL magic_we got %0d cycles want 0", we_cycles); end
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL magic_done got %b want 0", load_done); end
    do_clear();
  endtask

  task automatic test_overrun();
    ack_en = 1'b0;
    send_word(32'hBA110002);
    word_in = 32'hAAAA0001;
    word_valid = 1'b1;
    tick();
    tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL ovr_issue got we=%b want 1", mem_we); end
    word_in = 32'hAAAA0002;
    tick();
    word_valid = 1'b0;
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL ovr_we got %b want 0", mem_we); end
    tests++; if (error !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
      fails++; $display("FAIL ovr_err got err=%b code=%0d busy=%b want 1/2/0", error, err_code, busy);
    end
    do_clear();
    ack_en = 1'b1;
  endtask

  task automatic test_zero_len();
    send_word(32'hBA110000);
`ifdef PROG_LOADER_CHECKSUM_EN
    tests++; if (busy !== 1'b1 || load_done !== 1'b0) begin
      fails++; $display("FAIL zero_check got busy=%b done=%b want 1/0", busy, load_done);
    end
    send_word(32'h0);
`endif
    tests++; if (load_done !== 1'b1 || error !== 1'b0) begin
      fails++; $display("FAIL zero_done got done=%b err=%b want 1/0", load_done, error);
    end
    tests++; if (words_loaded !== '0) begin fails++; $display("FAIL zero_count got %0d want 0", words_loaded); end
    do_clear();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    w0 = $urandom;
    w1 = $urandom;
    ack_en = 1'b0;
    wr_log.delete();
    send_word(32'hBA110002);
    do_clear();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clear_in_load got busy=%b want 1", busy); end
    send_word(w0);
    word_in = w1;
    word_valid = 1'b1;
    mem_ack = 1'b1;
    tick();
    word_valid = 1'b0;
    tests++; if (mem_we !== 1'b1 || mem_addr !== AW'(1) || mem_wdata !== w1) begin
      fails++; $display("FAIL b2b_issue got we=%b %h:%h want 1 0001:%h", mem_we, mem_addr, mem_wdata, w1);
    end
    tests++; if (words_loaded !== 17'd1 || error !== 1'b0) begin
      fails++; $display("FAIL b2b_mid got count=%0d err=%b want 1/0", words_loaded, error);
    end
    tick();
    mem_ack = 1'b0;
    tests++; if (words_loaded !== 17'd2 || mem_we !== 1'b0) begin
      fails++; $display("FAIL b2b_end got count=%0d we=%b want 2/0", words_loaded, mem_we);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(w0 ^ w1);
`endif
    tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL b2b_done got %b want 1", load_done); end
    tests++; if (wr_log.size() != 2) begin
      fails++; $display("FAIL b2b_log got %0d writes want 2", wr_log.size());
    end else if (wr_log[0] !== {AW'(0), w0} || wr_log[1] !== {AW'(1), w1}) begin
      fails++; $display("FAIL b2b_data got %h %h want %h %h", wr_log[0], wr_log[1], {AW'(0), w0}, {AW'(1), w1});
    end
    do_clear();
    ack_en = 1'b1;
  endtask

  task automatic test_checksum();
    pl = '{32'hF0F0F0F0, 32'h0F0F0F0F};
    drive_load(32'hBA110002, 32'hFFFFFFFF);
    tests++; if (load_done !== 1'b1 || error !== 1'b0) begin
      fails++; $display("FAIL csum_good got done=%b err=%b want 1/0", load_done, error);
    end
    do_clear();
    drive_load(32'hBA110002, 32'hFFFFFFFE);
    tests++; if (error !== 1'b1 || err_code !== 2'd3 || load_done !== 1'b0) begin
      fails++; $display("FAIL csum_bad got err=%b code=%0d done=%b want 1/3/0", error, err_code, load_done);
    end
    tests++; if (words_loaded !== 17'd2) begin fails++; $display("FAIL csum_count got %0d want 2", words_loaded); end
    do_clear();
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int          n;
      bit          bad, corrupt;
      logic [15:0] mg;
      logic [31:0] x, cw;
      int          exp_writes;
      n = $urandom_range(1, 6);
      x = '0;
      pl.delete();
      for (int k = 0; k < n; k++) begin
        pl.push_back($urandom);
        x ^= pl[k];
      end
      ack_delay = $urandom_range(1, 3);
      bad = ($urandom_range(0, 3) == 0);
      mg = bad ? (MAGIC ^ 16'($urandom_range(1, 65535))) : MAGIC;
`ifdef PROG_LOADER_CHECKSUM_EN
      corrupt = ($urandom_range(0, 2) == 0);
`else
      corrupt = 1'b0;
`endif
      cw = corrupt ? (x ^ (32'd1 << $urandom_range(0, 31))) : x;
      drive_load({mg, 16'(n)}, cw);
      exp_writes = bad ? 0 : n;
      tests++; if (wr_log.size() != exp_writes) begin
        fails++; $display("FAIL rnd%0d_nwr got %0d want %0d", it, wr_log.size(), exp_writes);
      end else begin
        foreach (wr_log[i]) begin
          tests++;
          if (wr_log[i] !== {AW'(i), pl[i]}) begin
            fails++; $display("FAIL rnd%0d_wr%0d got %h want %h", it, i, wr_log[i], {AW'(i), pl[i]});
          end
        end
      end
      tests++; if (words_loaded !== (AW+1)'(exp_writes)) begin
        fails++; $display("FAIL rnd%0d_count got %0d want %0d", it, words_loaded, exp_writes);
      end
      tests++; if (load_done !== (!bad && !corrupt) || error !== (bad || corrupt) || busy !== 1'b0) begin
        fails++; $display("FAIL rnd%0d_flags got done=%b err=%b busy=%b bad=%0d corrupt=%0d",
                          it, load_done, error, busy, bad, corrupt);
      end
      tests++; if (err_code !== (bad ? 2'd1 : (corrupt ? 2'd3 : 2'd0))) begin
        fails++; $display("FAIL rnd%0d_code got %0d bad=%0d corrupt=%0d", it, err_code, bad, corrupt);
      end
      do_clear();
    end
  endtask

  task automatic test_reset_restart();
    ack_en = 1'b0;
    send_word(32'hBA110003);
    send_word(32'h12345678);
    tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL rr_we_pre got %b want 1", mem_we); end
    #2 rst = 1'b1;
    #1;
    tests++; if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== '0) begin
      fails++; $display("FAIL rr_async got we=%b busy=%b addr=%h data=%h cnt=%0d want all 0",
                        mem_we, busy, mem_addr, mem_wdata, words_loaded);
    end
    #1 rst = 1'b0;
    tick();
    ack_en = 1'b1;
    ack_delay = 1;
    pl = '{32'hCAFE0000, 32'hCAFE0001};
    drive_load(32'hBA110002, 32'hCAFE0000 ^ 32'hCAFE0001);
    tests++; if (load_done !== 1'b1 || wr_log.size() != 2) begin
      fails++; $display("FAIL rr_first got done=%b writes=%0d want 1/2", load_done, wr_log.size());
    end
    do_clear();
    pl = '{32'h5A5A5A5A};
    drive_load(32'hBA110001, 32'h5A5A5A5A);
    tests++; if (wr_log.size() != 1) begin
      fails++; $display("FAIL rr_second_n got %0d want 1", wr_log.size());
    end else if (wr_log[0] !== {AW'(0), 32'h5A5A5A5A}) begin
      fails++; $display("FAIL rr_second_wr got %h want %h", wr_log[0], {AW'(0), 32'h5A5A5A5A});
    end
    tests++; if (load_done !== 1'b1 || words_loaded !== 17'd1) begin
      fails++; $display("FAIL rr_second_done got done=%b cnt=%0d want 1/1", load_done, words_loaded);
    end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_magic();
    test_overrun();
    test_zero_len();
    test_back_to_back();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    test_reset_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
